// File: rtl/sad_trigger_sequencer_if.sv
// Control/status bundle between the capture controller and the SAD trigger sequencer.
// The master drives arm, match and configuration; the slave returns flush, trigger and status.
`timescale 1ns/1ps
interface sad_trigger_sequencer_if #(
    parameter int pCOUNT_WIDTH = 8
);
    logic                    armed_and_ready;
    logic                    sad_match;
    logic                    cfg_short;
    logic                    cfg_multiple;
    logic [3:0]              cfg_trig_width;
    logic                    status_clear;
    logic                    flush;
    logic                    trigger;
    logic                    triggered;
    logic [pCOUNT_WIDTH-1:0] trigger_count;
    logic [2:0]              state;

    modport master (
        output armed_and_ready, sad_match, cfg_short, cfg_multiple, cfg_trig_width, status_clear,
        input  flush, trigger, triggered, trigger_count, state
    );

    modport slave (
        input  armed_and_ready, sad_match, cfg_short, cfg_multiple, cfg_trig_width, status_clear,
        output flush, trigger, triggered, trigger_count, state
    );
endinterface

// File: rtl/sad_trigger_sequencer.sv
// Sequences window fill, match-triggered pulse and holdoff for a SAD pattern trigger.
// All outputs registered; trigger rises one cycle after a sampled match, no backpressure.
`timescale 1ns/1ps
module sad_trigger_sequencer #(
    parameter int pREF_SAMPLES = 32,
    parameter int pCOUNT_WIDTH = 8
) (
    input  logic                    clk_adc,
    input  logic                    reset_n,
    sad_trigger_sequencer_if.slave  bus
);

    localparam int CW = $clog2(pREF_SAMPLES) + 1;
    localparam logic [CW-1:0] LFULL_M1  = CW'(pREF_SAMPLES - 1);
    localparam logic [CW-1:0] LSHORT_M1 = CW'(pREF_SAMPLES / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_PULSE   = 3'd3,
        ST_HOLDOFF = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [CW-1:0]           r_win_cnt;
    logic [3:0]              r_pulse_cnt;
    logic [3:0]              r_width;
    logic                    r_short;
    logic                    r_multiple;
    logic                    r_flush;
    logic                    r_trigger;
    logic                    r_triggered;
    logic [pCOUNT_WIDTH-1:0] r_count;

    logic                    w_win_done;
    logic                    w_pulse_done;
    logic                    w_arm_entry;
    logic                    w_pulse_entry;

    // FILL and HOLDOFF share one window counter; it restarts on every state change.
    assign w_win_done    = (r_win_cnt == (r_short ? LSHORT_M1 : LFULL_M1));
    assign w_pulse_done  = (r_pulse_cnt == r_width);
    assign w_arm_entry   = (r_state == ST_IDLE) && (w_next == ST_FILL);
    assign w_pulse_entry = (r_state != ST_PULSE) && (w_next == ST_PULSE);

    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.armed_and_ready) w_next = ST_FILL;
            end
            ST_FILL: begin
                if (!bus.armed_and_ready) w_next = ST_IDLE;
                else if (w_win_done)      w_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!bus.armed_and_ready) w_next = ST_IDLE;
                else if (bus.sad_match)   w_next = ST_PULSE;
            end
            ST_PULSE: begin
                if (!bus.armed_and_ready) w_next = ST_IDLE;
                else if (w_pulse_done)    w_next = r_multiple ? ST_HOLDOFF : ST_DONE;
            end
            ST_HOLDOFF: begin
                if (!bus.armed_and_ready) w_next = ST_IDLE;
                else if (w_win_done)      w_next = ST_ACTIVE;
            end
            ST_DONE: begin
                if (!bus.armed_and_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs decode the next state so they line up with the state register.
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            r_win_cnt   <= '0;
            r_pulse_cnt <= '0;
            r_width     <= '0;
            r_short     <= 1'b0;
            r_multiple  <= 1'b0;
            r_flush     <= 1'b1;
            r_trigger   <= 1'b0;
            r_triggered <= 1'b0;
            r_count     <= '0;
        end else begin
            r_flush   <= (w_next == ST_IDLE);
            r_trigger <= (w_next == ST_PULSE);

            if (w_next != r_state) begin
                r_win_cnt   <= '0;
                r_pulse_cnt <= '0;
            end else begin
                if ((r_state == ST_FILL) || (r_state == ST_HOLDOFF)) r_win_cnt <= r_win_cnt + 1'b1;
                if (r_state == ST_PULSE) r_pulse_cnt <= r_pulse_cnt + 1'b1;
            end

            if (w_arm_entry) begin
                r_short    <= bus.cfg_short;
                r_multiple <= bus.cfg_multiple;
            end

            // A clear landing on the same edge as a new trigger still records that trigger.
            if (w_pulse_entry) begin
                r_width     <= bus.cfg_trig_width;
                r_triggered <= 1'b1;
                if (bus.status_clear)    r_count <= pCOUNT_WIDTH'(1);
                else if (r_count != '1)  r_count <= r_count + 1'b1;
            end else if (bus.status_clear) begin
                r_triggered <= 1'b0;
                r_count     <= '0;
            end
        end
    end

    assign bus.flush         = r_flush;
    assign bus.trigger       = r_trigger;
    assign bus.triggered     = r_triggered;
    assign bus.trigger_count = r_count;
    assign bus.state         = r_state;

endmodule

// File: doc/sad_trigger_sequencer.md
SAD_TRIGGER_SEQUENCER -- requirements
Module: sad_trigger_sequencer

Interface
REQ-001 SHALL have parameter pREF_SAMPLES, default 32; full reference length in samples (power of 2, 8..128).
REQ-002 SHALL have parameter pCOUNT_WIDTH, default 8; width of the trigger counter.
REQ-003 SHALL have port clk_adc  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port armed_and_ready  input  1  capture armed; level.
REQ-006 SHALL have port sad_match  input  1  datapath compare result (SAD < threshold) for the current window; meaningful only when the window is full.
REQ-007 SHALL have port cfg_short  input  1  1 = window length pREF_SAMPLES/2.
REQ-008 SHALL have port cfg_multiple  input  1  1 = re-trigger after holdoff; 0 = one trigger per arm.
REQ-009 SHALL have port cfg_trig_width  input  4  trigger pulse length minus 1, in cycles.
REQ-010 SHALL have port status_clear  input  1  single-cycle pulse; clears triggered and trigger_count.
REQ-011 SHALL have port flush  output  1  datapath window flush request.
REQ-012 SHALL have port trigger  output  1  trigger output.
REQ-013 SHALL have port triggered  output  1  sticky "at least one trigger" status.
REQ-014 SHALL have port trigger_count  output  pCOUNT_WIDTH  triggers since last clear, saturating.
REQ-015 SHALL have port state  output  3  current FSM state encoding, for debug readback.

Function
REQ-016 SHALL define L = pREF_SAMPLES/2 when cfg_short=1, else pREF_SAMPLES; cfg_short and cfg_multiple sampled only on the IDLE->FILL transition.
REQ-017 SHALL implement states IDLE=0, FILL=1, ACTIVE=2, PULSE=3, HOLDOFF=4, DONE=5; other encodings SHALL go to IDLE next cycle.
REQ-018 IDLE: flush=1; on armed_and_ready=1 SHALL go to FILL with fill counter cleared.
REQ-019 FILL: flush=0; counts cycles; after exactly L cycles in FILL SHALL go to ACTIVE; sad_match ignored.
REQ-020 ACTIVE: on sad_match=1 SHALL go to PULSE; trigger SHALL rise on the first cycle in PULSE (1 cycle after the sampled match).
REQ-021 PULSE: trigger=1 for exactly cfg_trig_width+1 cycles (width latched on entry), then HOLDOFF if cfg_multiple=1, else DONE.
REQ-022 HOLDOFF: trigger=0, sad_match ignored for L cycles counted from PULSE exit, then ACTIVE; prevents re-trigger on overlapping windows.
REQ-023 DONE: trigger=0, flush=0; remains until armed_and_ready=0.
REQ-024 In any non-IDLE state, armed_and_ready=0 SHALL force IDLE next cycle, terminating any pulse in progress (trigger=0 that cycle).
REQ-025 trigger, flush, triggered SHALL be registered outputs (no combinational path from inputs).
REQ-026 On entry to PULSE, triggered SHALL set and trigger_count SHALL increment, saturating at all-ones.
REQ-027 status_clear coincident with a PULSE entry SHALL result in triggered=1, trigger_count=1.
REQ-028 FILL and HOLDOFF counters SHALL be ceil(log2(pREF_SAMPLES))+1 bits wide; no wrap before reaching L.

Reset
REQ-029 While reset_n=0: state=IDLE, flush=1, trigger=0, triggered=0, trigger_count=0, all counters 0.
REQ-030 Reset deassertion SHALL be consumed synchronously; first possible FILL entry is the first edge after release with armed_and_ready=1.

Verification
REQ-031 pREF_SAMPLES=32, cfg_short=0, arm, sad_match held 1 -> trigger rises exactly 33 cycles after first armed edge; width=cfg_trig_width+1.
REQ-032 cfg_multiple=1, cfg_trig_width=0, sad_match held 1 -> pulses of 1 cycle spaced 34 cycles apart; trigger_count increments each pulse.
REQ-033 cfg_multiple=0, three matches -> exactly one pulse, state=DONE, trigger_count=1; disarm -> IDLE, flush=1.
REQ-034 Disarm on 2nd cycle of a width-8 pulse -> trigger=0 next cycle, state=IDLE, count still incremented once.
REQ-035 cfg_short=1, match asserted at FILL cycle 10 then held -> trigger rises 17 cycles after arm (ignored during FILL).
REQ-036 pCOUNT_WIDTH=2, 5 triggers -> trigger_count=3; status_clear with simultaneous trigger -> count=1, triggered=1; reset_n low mid-PULSE -> all outputs at reset values immediately.
